// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one combinational ALU through an IDLE/EXEC/RESP sequence.
// Latency: the response is valid two cycles after the accept cycle; back-to-back issue every 3 cycles.
// Backpressure: the response holds while resp ready is low; nothing new is accepted until back in IDLE.
package alu_arbiter_pkg;
    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADDU  = 4'd1,
        OP_SUBU  = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_BEQZ  = 4'd6,
        OP_BNEQZ = 4'd7
    } opcode_e;

    typedef struct packed {
        opcode_e     opcode;
        logic [11:0] imm;
    } instruction_s;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid_i,
    input  logic [DATA_W-1:0] req0_rd_i,
    input  logic [DATA_W-1:0] req0_rs_i,
    input  instruction_s      req0_op_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [DATA_W-1:0] req1_rd_i,
    input  logic [DATA_W-1:0] req1_rs_i,
    input  instruction_s      req1_op_i,
    output logic              req1_ready_o,
    output logic              resp0_valid_o,
    output logic [DATA_W-1:0] resp0_result_o,
    output logic              resp0_jump_o,
    input  logic              resp0_ready_i,
    output logic              resp1_valid_o,
    output logic [DATA_W-1:0] resp1_result_o,
    output logic              resp1_jump_o,
    input  logic              resp1_ready_i,
    output logic [DATA_W-1:0] alu_rd_o,
    output logic [DATA_W-1:0] alu_rs_o,
    output instruction_s      alu_op_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_jump_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  grant_cnt0_o,
    output logic [CNT_W-1:0]  grant_cnt1_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q;
    logic              win_q;
    logic              win_d;
    logic              accept;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rs_q;
    instruction_s      op_q;
    logic [DATA_W-1:0] result_q [2];
    logic [1:0]        jump_q;
    logic [CNT_W-1:0]  cnt_q [2];

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        win_d         = 1'b0;
        alu_rd_o      = '0;
        alu_rs_o      = '0;
        alu_op_o      = '0;
        resp0_valid_o = 1'b0;
        resp1_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    accept  = 1'b1;
                    // On a tie the requester that did not win last time goes first.
                    win_d   = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_rd_o = rd_q;
                alu_rs_o = rs_q;
                alu_op_o = op_q;
                state_d  = RESP;
            end
            RESP: begin
                resp0_valid_o = ~win_q;
                resp1_valid_o = win_q;
                if (win_q ? resp1_ready_i : resp0_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            rd_q         <= '0;
            rs_q         <= '0;
            op_q         <= '0;
            result_q[0]  <= '0;
            result_q[1]  <= '0;
            jump_q       <= '0;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= win_d;
                win_q        <= win_d;
                rd_q         <= win_d ? req1_rd_i : req0_rd_i;
                rs_q         <= win_d ? req1_rs_i : req0_rs_i;
                op_q         <= win_d ? req1_op_i : req0_op_i;
                if (cnt_q[win_d] != {CNT_W{1'b1}}) begin
                    cnt_q[win_d] <= cnt_q[win_d] + CNT_W'(1);
                end
            end
            if (state_q == EXEC) begin
                result_q[win_q] <= alu_result_i;
                jump_q[win_q]   <= alu_jump_i;
            end
        end
    end

    assign req0_ready_o   = accept & ~win_d;
    assign req1_ready_o   = accept & win_d;
    assign resp0_result_o = result_q[0];
    assign resp1_result_o = result_q[1];
    assign resp0_jump_o   = jump_q[0];
    assign resp1_jump_o   = jump_q[1];
    assign busy_o         = (state_q != IDLE);
    assign grant_cnt0_o   = cnt_q[0];
    assign grant_cnt1_o   = cnt_q[1];

endmodule
